// File: rtl/chan_pipe_array.sv
// Collects CHANNELS words into a frame, then pushes each channel through a STAGES-deep op pipeline and XOR-combines them.
// Latency: the output is valid STAGES edges after the frame's last word is accepted. Optional out_parity port: CHAN_PIPE_PARITY_EN.
// Backpressure: the whole pipeline freezes on out_valid && !out_ready. Input stalls (in_ready low) while a full frame waits to issue.
module chan_pipe_array #(
    parameter int          WIDTH    = 32,
    parameter int          CHANNELS = 5,
    parameter int          STAGES   = 5,
    parameter logic [63:0] KEY      = 64'h0000_0000_A5A5_A5A5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHANNELS-1:0] chan_en,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef CHAN_PIPE_PARITY_EN
    output logic                out_parity,
`endif
    output logic [15:0]         frame_cnt
);

    localparam int              CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WIDTH-1:0] KEY_W = KEY[WIDTH-1:0];

    logic [WIDTH-1:0]  r_slot [CHANNELS];
    logic [CW-1:0]     r_slot_cnt;
    logic              r_frame_full;
    logic [WIDTH-1:0]  r_dat [CHANNELS][STAGES];
    // Per-channel enable rides alongside the data so a disabled lane stays zero through every op.
    logic [STAGES-1:0] r_en [CHANNELS];
    logic [STAGES-1:0] r_vld;
    logic [15:0]       r_frame_cnt;

    logic              w_advance;
    logic              w_issue;
    logic              w_accept;
    logic [WIDTH-1:0]  w_out_data;

    function automatic logic [WIDTH-1:0] f_op(input int sel, input logic [WIDTH-1:0] d);
        case (sel)
            0:       f_op = ~d;
            1:       f_op = {d[WIDTH-2:0], d[WIDTH-1]};
            default: f_op = d ^ KEY_W;
        endcase
    endfunction

    assign w_advance = !r_vld[STAGES-1] || out_ready;
    assign w_issue   = r_frame_full && w_advance;
    assign w_accept  = in_valid && !r_frame_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_cnt   <= '0;
            r_frame_full <= 1'b0;
            for (int j = 0; j < CHANNELS; j++) r_slot[j] <= '0;
        end else if (w_accept) begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (r_slot_cnt == CW'(j)) r_slot[j] <= in_data;
            end
            if (r_slot_cnt == CW'(CHANNELS - 1)) begin
                r_slot_cnt   <= '0;
                r_frame_full <= 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end else if (w_issue) begin
            r_frame_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_en[c] <= '0;
                for (int s = 0; s < STAGES; s++) r_dat[c][s] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= w_issue;
            for (int s = 1; s < STAGES; s++) r_vld[s] <= r_vld[s-1];
            for (int c = 0; c < CHANNELS; c++) begin
                r_en[c][0]  <= w_issue && chan_en[c];
                r_dat[c][0] <= (w_issue && chan_en[c]) ? f_op(c % 3, r_slot[c]) : '0;
                for (int s = 1; s < STAGES; s++) begin
                    r_en[c][s]  <= r_en[c][s-1];
                    r_dat[c][s] <= r_en[c][s-1] ? f_op((c + s) % 3, r_dat[c][s-1]) : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (r_vld[STAGES-1] && out_ready) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int c = 0; c < CHANNELS; c++) w_out_data = w_out_data ^ r_dat[c][STAGES-1];
    end

    assign out_data  = w_out_data;
    assign out_valid = r_vld[STAGES-1];
    assign in_ready  = !r_frame_full;
    assign frame_cnt = r_frame_cnt;
`ifdef CHAN_PIPE_PARITY_EN
    assign out_parity = ^w_out_data;
`endif

endmodule

// File: tb/tb_chan_pipe_array.sv
// Scoreboard bench for chan_pipe_array: three parameterisations driven by directed frames.
module tb_chan_pipe_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // a: defaults (5 ch, 5 stages); b: 1 ch, 3 stages; c: 2 ch, 1 stage
    logic [31:0] a_in_data, b_in_data, c_in_data;
    logic        a_in_valid, b_in_valid, c_in_valid;
    logic        a_in_ready, b_in_ready, c_in_ready;
    logic [4:0]  a_chan_en;
    logic [0:0]  b_chan_en;
    logic [1:0]  c_chan_en;
    logic [31:0] a_out_data, b_out_data, c_out_data;
    logic        a_out_valid, b_out_valid, c_out_valid;
    logic        a_out_ready, b_out_ready, c_out_ready;
    logic [15:0] a_frame_cnt, b_frame_cnt, c_frame_cnt;
`ifdef CHAN_PIPE_PARITY_EN
    logic        a_out_parity, b_out_parity, c_out_parity;
`endif

    chan_pipe_array dut_a (
        .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .chan_en(a_chan_en), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef CHAN_PIPE_PARITY_EN
        .out_parity(a_out_parity),
`endif
        .frame_cnt(a_frame_cnt)
    );

    chan_pipe_array #(.CHANNELS(1), .STAGES(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .chan_en(b_chan_en), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef CHAN_PIPE_PARITY_EN
        .out_parity(b_out_parity),
`endif
        .frame_cnt(b_frame_cnt)
    );

    chan_pipe_array #(.CHANNELS(2), .STAGES(1)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .chan_en(c_chan_en), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
`ifdef CHAN_PIPE_PARITY_EN
        .out_parity(c_out_parity),
`endif
        .frame_cnt(c_frame_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] qa[$], qb[$], qc[$];
    logic [15:0] cnt_a = 16'd0, cnt_b = 16'd0, cnt_c = 16'd0;
    int seen_a = 0;
    logic [31:0] ea, eb, ec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0][31:0] ws, input logic [4:0] en);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        for (int c = 0; c < 5; c++) begin
            if (en[c]) begin
                v = ws[c];
                for (int s = 0; s < 5; s++) begin
                    case ((c + s) % 3)
                        0:       v = ~v;
                        1:       v = {v[30:0], v[31]};
                        default: v = v ^ 32'hA5A5A5A5;
                    endcase
                end
                r = r ^ v;
            end
        end
        return r;
    endfunction

    // Monitors: pop and compare on every output handshake
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected: output %h with empty scoreboard", a_out_data);
            end else begin
                ea = qa.pop_front();
                check("a_data", {32'h0, a_out_data}, {32'h0, ea});
                check("a_frame_cnt", {48'h0, a_frame_cnt}, {48'h0, cnt_a});
`ifdef CHAN_PIPE_PARITY_EN
                check("a_parity", {63'h0, a_out_parity}, {63'h0, ^ea});
`endif
                cnt_a++;
                seen_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected: output %h with empty scoreboard", b_out_data);
            end else begin
                eb = qb.pop_front();
                check("b_data", {32'h0, b_out_data}, {32'h0, eb});
                check("b_frame_cnt", {48'h0, b_frame_cnt}, {48'h0, cnt_b});
`ifdef CHAN_PIPE_PARITY_EN
                check("b_parity", {63'h0, b_out_parity}, {63'h0, ^eb});
`endif
                cnt_b++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL c_unexpected: output %h with empty scoreboard", c_out_data);
            end else begin
                ec = qc.pop_front();
                check("c_data", {32'h0, c_out_data}, {32'h0, ec});
                check("c_frame_cnt", {48'h0, c_frame_cnt}, {48'h0, cnt_c});
`ifdef CHAN_PIPE_PARITY_EN
                check("c_parity", {63'h0, c_out_parity}, {63'h0, ^ec});
`endif
                cnt_c++;
            end
        end
    end

    task automatic drive(input int inst, input logic [31:0] w, input logic v);
        case (inst)
            0:       begin a_in_data = w; a_in_valid = v; end
            1:       begin b_in_data = w; b_in_valid = v; end
            default: begin c_in_data = w; c_in_valid = v; end
        endcase
    endtask

    function automatic logic ready(input int inst);
        case (inst)
            0:       return a_in_ready;
            1:       return b_in_ready;
            default: return c_in_ready;
        endcase
    endfunction

    function automatic int qsize(input int inst);
        case (inst)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic push(input int inst, input logic [31:0] v);
        case (inst)
            0:       qa.push_back(v);
            1:       qb.push_back(v);
            default: qc.push_back(v);
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int inst, input logic [31:0] w);
        int t;
        logic acc;
        t = 0;
        acc = 1'b0;
        drive(inst, w, 1'b1);
        while (!acc && t < 200) begin
            acc = ready(inst);
            @(posedge clk); #1;
            t++;
        end
        drive(inst, 32'h0, 1'b0);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: inst %0d word %h not accepted", inst, w);
        end
    endtask

    task automatic frame5(input logic [31:0] w0, w1, w2, w3, w4);
        logic [4:0][31:0] ws;
        ws = {w4, w3, w2, w1, w0};
        for (int j = 0; j < 5; j++) send(0, ws[j]);
        push(0, model(ws, a_chan_en));
    endtask

    task automatic drain(input int inst);
        int t;
        t = 0;
        while (qsize(inst) != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 64'(qsize(inst)), 64'd0);
    endtask

    logic [31:0] hold_d;
    logic [31:0] stall_exp;
    logic        got, stable;
    int          seen_base;

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;
        a_chan_en = 5'b11111; b_chan_en = 1'b1; c_chan_en = 2'b11;
        a_out_ready = 1; b_out_ready = 1; c_out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        check("rst_a_valid", {63'h0, a_out_valid}, 64'd0);
        check("rst_a_data", {32'h0, a_out_data}, 64'd0);
        check("rst_a_ready", {63'h0, a_in_ready}, 64'd1);
        check("rst_a_cnt", {48'h0, a_frame_cnt}, 64'd0);
        check("rst_b_valid", {63'h0, b_out_valid}, 64'd0);
        check("rst_b_ready", {63'h0, b_in_ready}, 64'd1);
        check("rst_c_valid", {63'h0, c_out_valid}, 64'd0);
        check("rst_c_data", {32'h0, c_out_data}, 64'd0);

        // 1 channel, 3 stages: ~1 -> rotl -> ^KEY, valid 3 edges after acceptance
        send(1, 32'h0000_0001);
        push(1, 32'h5A5A_5A58);
        check("b_lat_k0", {63'h0, b_out_valid}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b_lat_k2", {63'h0, b_out_valid}, 64'd0);
        @(posedge clk); #1;
        check("b_lat_k3", {63'h0, b_out_valid}, 64'd1);
        drain(1);

        // 2 channels, 1 stage: ch0 invert, ch1 rotate
        c_chan_en = 2'b11;
        send(2, 32'h1); send(2, 32'h2);
        push(2, 32'hFFFF_FFFA);
        drain(2);
        c_chan_en = 2'b01;
        send(2, 32'h1); send(2, 32'h2);
        push(2, 32'hFFFF_FFFE);
        drain(2);

        // Default config, several enable patterns
        a_chan_en = 5'b11111;
        frame5(32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
        drain(0);
        a_chan_en = 5'b10101;
        frame5(32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h0, 32'h80000001);
        drain(0);
        a_chan_en = 5'b00000;
        frame5(32'hCAFEF00D, 32'h1, 32'h2, 32'h3, 32'h4);
        drain(0);
        a_chan_en = 5'b11110;
        frame5(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000080);
        drain(0);

        // Stall: out_ready low for 20 cycles with continuous input
        a_chan_en = 5'b11111;
        a_out_ready = 0;
        seen_base = seen_a;
        stall_exp = model({32'h15, 32'h14, 32'h13, 32'h12, 32'h11}, 5'b11111);
        got = 0; stable = 1; hold_d = '0;
        fork
            begin
                frame5(32'h11, 32'h12, 32'h13, 32'h14, 32'h15);
                frame5(32'h21, 32'h22, 32'h23, 32'h24, 32'h25);
                frame5(32'h31, 32'h32, 32'h33, 32'h34, 32'h35);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (got) stable = stable && a_out_valid && (a_out_data == hold_d);
                    else if (a_out_valid) begin got = 1; hold_d = a_out_data; end
                end
                check("stall_valid", {63'h0, got}, 64'd1);
                check("stall_hold", {63'h0, stable}, 64'd1);
                check("stall_in_ready", {63'h0, a_in_ready}, 64'd0);
                check("stall_data", {32'h0, hold_d}, {32'h0, stall_exp});
                a_out_ready = 1;
            end
        join
        drain(0);
        check("stall_frames", 64'(seen_a - seen_base), 64'd3);

        // Reset with a stalled frame in flight and 3 of 5 words collected
        a_out_ready = 0;
        frame5(32'h41, 32'h42, 32'h43, 32'h44, 32'h45);
        send(0, 32'h51); send(0, 32'h52); send(0, 32'h53);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        qa.delete(); qb.delete(); qc.delete();
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        check("mid_rst_valid", {63'h0, a_out_valid}, 64'd0);
        check("mid_rst_ready", {63'h0, a_in_ready}, 64'd1);
        check("mid_rst_cnt", {48'h0, a_frame_cnt}, 64'd0);
        check("mid_rst_data", {32'h0, a_out_data}, 64'd0);
        a_out_ready = 1;
        frame5(32'h61, 32'h62, 32'h63, 32'h64, 32'h65);
        drain(0);

        // frame_cnt wrap: preload 16'hFFFF, one handshake
        force dut_b.r_frame_cnt = 16'hFFFF;
        #1;
        release dut_b.r_frame_cnt;
        cnt_b = 16'hFFFF;
        check("wrap_pre", {48'h0, b_frame_cnt}, 64'h0000_0000_0000_FFFF);
        send(1, 32'h0000_0001);
        push(1, 32'h5A5A_5A58);
        drain(1);
        check("wrap_post", {48'h0, b_frame_cnt}, 64'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
